sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO, successor to sync_fifo. Adds configurable width/depth,

---
 rtl/sync_fifo_param_pkg.sv | 25 ++
 rtl/sync_fifo_param_if.sv | 38 +++
 rtl/sync_fifo_param_mem.sv | 35 +++
 rtl/sync_fifo_param.sv | 144 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Package: sync_fifo_pkg
// Purpose: shared types, default sizes and helper for the parametrised
//          single-clock FIFO (sync_fifo_param) and its sub-blocks.
// Contents:
//   fifo_flags_t    registered status flags {full, empty, almost_full, almost_empty}
//   DEFAULT_DATA_W  default data width
//   DEFAULT_DEPTH   default number of entries
//   clog2_depth()   address width for a given depth (never below 1)
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  function automatic int clog2_depth(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Interface: sync_fifo_param_if
// Purpose: producer/consumer bundle of the single-clock FIFO.
// Modports:
//   master  drives clear, write_en, data_in, read_en; observes data/status
//   slave   the FIFO side (drives data_out, full, empty, almost_full,
//           almost_empty, count, overflow, underflow)
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
);
  localparam int CNT_W = clog2_depth(DEPTH) + 1;

  logic              clear;
  logic              write_en;
  logic [DATA_W-1:0] data_in;
  logic              read_en;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clear, write_en, data_in, read_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clear, write_en, data_in, read_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_mem.sv
// Module: sync_fifo_mem
// Purpose: DEPTH x DATA_W storage, one synchronous write port and one
//          asynchronous (address-indexed) read port. No reset: contents
//          survive reset and flush.
// Ports:
//   clk       clock, rising edge
//   we_i      write enable
//   waddr_i   write index
//   wdata_i   write data
//   raddr_i   read index
//   rdata_o   read data (combinational from raddr_i)
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = clog2_depth(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Module: sync_fifo_param
// Purpose: parametrised single-clock FIFO with occupancy count,
//          almost_full/almost_empty thresholds, sticky overflow/underflow
//          and synchronous flush (clear).
// Ports:
//   clk     clock, rising edge
//   reset   asynchronous, active-low reset
//   bus     sync_fifo_param_if.slave (clear, write_en, data_in, read_en in;
//           data_out, full, empty, almost_full, almost_empty, count,
//           overflow, underflow out)
// Configuration:
//   SYNC_FIFO_FWFT_EN  defined   -> first-word-fall-through: data_out shows
//                                   the head word whenever not empty, 0 when empty
//                      undefined -> registered read, head word on data_out
//                                   after the accepting edge
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  sync_fifo_param_if.slave  bus
);

  localparam int ADDR_W = clog2_depth(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $fatal(1, "sync_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $fatal(1, "sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  fifo_flags_t       flags_q, flags_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_ok, wr_ok;
  logic [DATA_W-1:0] mem_rdata;

  always_comb begin
    rd_ok = bus.read_en & ~flags_q.empty;
    // a full FIFO still takes a write when the same cycle frees a slot
    wr_ok = bus.write_en & (~flags_q.full | rd_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (bus.write_en & ~wr_ok) ovf_d = 1'b1;
      if (bus.read_en & ~rd_ok)  unf_d = 1'b1;
    end

    // the wrap bit makes the pointer difference span 0..DEPTH
    count_d = wr_ptr_d - rd_ptr_d;

    flags_d.full         = (count_d == DEPTH_C);
    flags_d.empty        = (count_d == '0);
    flags_d.almost_full  = (count_d >= AF_C);
    flags_d.almost_empty = (count_d <= AE_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok & ~bus.clear),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = flags_q.empty ? '0 : mem_rdata;
`else
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (bus.clear)  data_d = '0;
    else if (rd_ok) data_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_q <= '0;
    else        data_q <= data_d;
  end

  assign bus.data_out = data_q;
`endif

  assign bus.full         = flags_q.full;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param (DATA_W=8, DEPTH=8, AF=6, AE=2).
// Works with SYNC_FIFO_FWFT_EN defined or undefined.
module tb_sync_fifo_param;

  logic clk;
  logic reset;

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) bus ();

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: scoreboard queue + sticky flags + registered output
  logic [7:0] sb[$];
  logic       m_ovf;
  logic       m_unf;
  logic [7:0] m_dout;

  typedef struct {
    bit         clr, we, re;
    logic [7:0] din;
    int         cnt;
    bit         full, empty, af, ae, ovf, unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit clr, bit we, logic [7:0] din, bit re, int cnt,
                              bit full, bit empty, bit af, bit ae, bit ovf, bit unf);
    vec_t v;
    v.clr = clr; v.we = we; v.din = din; v.re = re; v.cnt = cnt;
    v.full = full; v.empty = empty; v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_data();
`ifdef SYNC_FIFO_FWFT_EN
    return (sb.size() != 0) ? sb[0] : 8'd0;
`else
    return m_dout;
`endif
  endfunction

  task automatic model_reset();
    sb.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = 8'd0;
  endtask

  task automatic model_edge(input bit clr, input bit we, input logic [7:0] din, input bit re);
    bit m_full, m_empty, rd_ok, wr_ok;
    logic [7:0] v;
    if (clr) begin
      model_reset();
      return;
    end
    m_full  = (sb.size() == 8);
    m_empty = (sb.size() == 0);
    rd_ok   = re && !m_empty;
    wr_ok   = we && (!m_full || rd_ok);
    if (we && !wr_ok) m_ovf = 1'b1;
    if (re && m_empty) m_unf = 1'b1;
    if (rd_ok) begin
      v = sb.pop_front();
      m_dout = v;
    end
    if (wr_ok) sb.push_back(din);
  endtask

  task automatic check_model(input string tag);
    int n;
    n = sb.size();
    chk({tag, ".count"}, 32'(bus.count), 32'(n));
    chk({tag, ".full"},  32'(bus.full),  32'(n == 8));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
    chk({tag, ".afull"}, 32'(bus.almost_full),  32'(n >= 6));
    chk({tag, ".aempty"},32'(bus.almost_empty), 32'(n <= 2));
    chk({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
    chk({tag, ".unf"},   32'(bus.underflow), 32'(m_unf));
    chk({tag, ".data"},  32'(bus.data_out),  32'(exp_data()));
  endtask

  task automatic step(input string tag, input bit clr, input bit we,
                      input logic [7:0] din, input bit re);
    @(negedge clk);
    bus.clear    = clr;
    bus.write_en = we;
    bus.data_in  = din;
    bus.read_en  = re;
    @(posedge clk);
    model_edge(clr, we, din, re);
    #1;
    check_model(tag);
  endtask

  initial begin
    bus.clear = 1'b0; bus.write_en = 1'b0; bus.read_en = 1'b0; bus.data_in = 8'd0;
    reset = 1'b0;
    model_reset();

    // fill/drain vectors from an empty FIFO
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(0, 1, 8'(k), 0, k + 1, k == 7, 0, k >= 5, k <= 1, 0, 0));
    end
    vecs.push_back(mk(0, 1, 8'd99, 0, 8, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 7, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 6, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 5, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 4, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 3, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 2, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'd0, 1, 0, 0, 1, 0, 1, 1, 1));

    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_model("por");
    @(negedge clk);
    reset = 1'b1;

    // reset mid-traffic
    step("pre_rst_w0", 0, 1, 8'h11, 0);
    step("pre_rst_w1", 0, 1, 8'h22, 0);
    step("pre_rst_wr", 0, 1, 8'h33, 1);
    @(negedge clk);
    bus.write_en = 1'b1;
    bus.read_en  = 1'b1;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("mid_rst");
    chk("mid_rst.data_zero", 32'(bus.data_out), 32'd0);
    @(negedge clk);
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    reset = 1'b1;

    // table: fill, overflow, drain, underflow
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].clr, vecs[i].we, vecs[i].din, vecs[i].re);
      chk($sformatf("vec%0d.count", i), 32'(bus.count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d.full", i),  32'(bus.full),  32'(vecs[i].full));
      chk($sformatf("vec%0d.empty", i), 32'(bus.empty), 32'(vecs[i].empty));
      chk($sformatf("vec%0d.afull", i), 32'(bus.almost_full),  32'(vecs[i].af));
      chk($sformatf("vec%0d.aempty", i),32'(bus.almost_empty), 32'(vecs[i].ae));
      chk($sformatf("vec%0d.ovf", i),   32'(bus.overflow),  32'(vecs[i].ovf));
      chk($sformatf("vec%0d.unf", i),   32'(bus.underflow), 32'(vecs[i].unf));
    end
`ifdef SYNC_FIFO_FWFT_EN
    chk("drain_extra.data", 32'(bus.data_out), 32'd0);
`else
    chk("drain_extra.hold7", 32'(bus.data_out), 32'd7);
`endif

    // wrap-around
    for (int k = 0; k < 8; k++) step("wrap_w1", 0, 1, 8'(30 + k), 0);
    chk("wrap.count8", 32'(bus.count), 32'd8);
    for (int k = 0; k < 4; k++) step("wrap_r1", 0, 0, 8'd0, 1);
    for (int k = 0; k < 4; k++) step("wrap_w2", 0, 1, 8'(40 + k), 0);
    for (int k = 0; k < 8; k++) step("wrap_r2", 0, 0, 8'd0, 1);
    chk("wrap.count0", 32'(bus.count), 32'd0);

    // simultaneous read/write at full and at empty
    step("clr0", 1, 0, 8'd0, 0);
    for (int k = 0; k < 8; k++) step("sim_fill", 0, 1, 8'(50 + k), 0);
    step("sim_full_wr", 0, 1, 8'd60, 1);
    chk("sim_full.count", 32'(bus.count), 32'd8);
    chk("sim_full.ovf", 32'(bus.overflow), 32'd0);
    for (int k = 0; k < 8; k++) step("sim_drain", 0, 0, 8'd0, 1);
    step("sim_empty_wr", 0, 1, 8'd5, 1);
    chk("sim_empty.count", 32'(bus.count), 32'd1);
    chk("sim_empty.unf", 32'(bus.underflow), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("sim_empty.head5", 32'(bus.data_out), 32'd5);
    step("sim_read5", 0, 0, 8'd0, 1);
`else
    step("sim_read5", 0, 0, 8'd0, 1);
    chk("sim_read5.data", 32'(bus.data_out), 32'd5);
`endif

    // flush with a competing write; stickies are set beforehand
    step("ovf_set", 0, 0, 8'd0, 1);
    for (int k = 0; k < 8; k++) step("clr_fill", 0, 1, 8'(70 + k), 0);
    step("ovf_set2", 0, 1, 8'd0, 0);
    for (int k = 0; k < 3; k++) step("clr_rd", 0, 0, 8'd0, 1);
    chk("pre_clear.count", 32'(bus.count), 32'd5);
    step("clear", 1, 1, 8'd77, 0);
    chk("clear.count", 32'(bus.count), 32'd0);
    chk("clear.empty", 32'(bus.empty), 32'd1);
    chk("clear.ovf", 32'(bus.overflow), 32'd0);
    chk("clear.unf", 32'(bus.underflow), 32'd0);

    // random traffic against the scoreboard
    for (int c = 0; c < 1000; c++) begin
      int pw;
      pw = ((c / 100) % 3 == 0) ? 80 : (((c / 100) % 3 == 1) ? 20 : 50);
      step("rand",
           $urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < pw,
           8'($urandom_range(0, 255)),
           $urandom_range(0, 99) < (100 - pw));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
